n64_vdemux_gen: RTL

- Parametrised next-generation N64 video demultiplexer.
- Decodes the multiplexed VI bus (one sync cycle per pixel followed by R, G, B cycles) into registered parallel RGB of configurable width, with separate sync outputs.
- Provides robust NTSC/PAL detection by full line count, 480i detection, and VI-deblur pixel blanking.
- Adds incomplete-pixel protection and a pixel strobe for downstream scalers and DACs.

---
 rtl/n64rgb_pkg.sv | 51 +++++
 rtl/n64_vdemux_gen_if.sv | 39 +++
 rtl/n64_sync_analyzer.sv | 75 +++++++
 rtl/n64_vdemux_gen.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/n64rgb_pkg.sv
// n64rgb_pkg
// Shared definitions for the N64 VI demultiplexer slice.
// Contents:
//   SYNC_* : bit positions of the sync flags inside the sync-cycle nibble
//   phase_t : pixel phase encoding (R, G, B capture, then DONE)
//   PAL_THRESH_DEF / MIN_LINES_DEF : default field line-count thresholds
//   BAR_* / test_bar() : RGB on/off triplets of the 8 vertical test bars
package n64rgb_pkg;

  localparam int SYNC_VSYNC = 3;
  localparam int SYNC_CLAMP = 2;
  localparam int SYNC_HSYNC = 1;
  localparam int SYNC_CSYNC = 0;

  typedef enum logic [1:0] {
    PH_R    = 2'd0,
    PH_G    = 2'd1,
    PH_B    = 2'd2,
    PH_DONE = 2'd3
  } phase_t;

  localparam int PAL_THRESH_DEF = 288;
  localparam int MIN_LINES_DEF  = 200;

  // {R,G,B} on/off per bar, left to right
  localparam logic [2:0] BAR_WHITE   = 3'b111;
  localparam logic [2:0] BAR_YELLOW  = 3'b110;
  localparam logic [2:0] BAR_CYAN    = 3'b011;
  localparam logic [2:0] BAR_GREEN   = 3'b010;
  localparam logic [2:0] BAR_MAGENTA = 3'b101;
  localparam logic [2:0] BAR_RED     = 3'b100;
  localparam logic [2:0] BAR_BLUE    = 3'b001;
  localparam logic [2:0] BAR_BLACK   = 3'b000;

  function automatic logic [2:0] test_bar(input logic [2:0] idx);
    logic [2:0] rgb;
    rgb = BAR_BLACK;
    case (idx)
      3'd0: rgb = BAR_WHITE;
      3'd1: rgb = BAR_YELLOW;
      3'd2: rgb = BAR_CYAN;
      3'd3: rgb = BAR_GREEN;
      3'd4: rgb = BAR_MAGENTA;
      3'd5: rgb = BAR_RED;
      3'd6: rgb = BAR_BLUE;
      default: rgb = BAR_BLACK;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/n64_vdemux_gen_if.sv
// n64_vdemux_gen_if
// Bundles the VI input bus and the demultiplexed video outputs.
// Ports (signals):
//   nDSYNC_i, D_i[IN_W], nViDeBlur_i, TestPat_i : VI source -> demux
//   R_o/G_o/B_o[OUT_W], nVSYNC_o, nCLAMP_o, nHSYNC_o, nCSYNC_o,
//   PIXEL_VALID_o, PALMODE_o, N64_480I_o, PHASE_ERR_o : demux -> sink
// Modports: master = VI source / consumer side, slave = demultiplexer.
interface n64_vdemux_gen_if #(
  parameter int IN_W  = 7,
  parameter int OUT_W = 8
);
  logic             nDSYNC_i;
  logic [IN_W-1:0]  D_i;
  logic             nViDeBlur_i;
  logic             TestPat_i;
  logic [OUT_W-1:0] R_o;
  logic [OUT_W-1:0] G_o;
  logic [OUT_W-1:0] B_o;
  logic             nVSYNC_o;
  logic             nCLAMP_o;
  logic             nHSYNC_o;
  logic             nCSYNC_o;
  logic             PIXEL_VALID_o;
  logic             PALMODE_o;
  logic             N64_480I_o;
  logic             PHASE_ERR_o;

  modport master (
    output nDSYNC_i, D_i, nViDeBlur_i, TestPat_i,
    input  R_o, G_o, B_o, nVSYNC_o, nCLAMP_o, nHSYNC_o, nCSYNC_o,
           PIXEL_VALID_o, PALMODE_o, N64_480I_o, PHASE_ERR_o
  );

  modport slave (
    input  nDSYNC_i, D_i, nViDeBlur_i, TestPat_i,
    output R_o, G_o, B_o, nVSYNC_o, nCLAMP_o, nHSYNC_o, nCSYNC_o,
           PIXEL_VALID_o, PALMODE_o, N64_480I_o, PHASE_ERR_o
  );
endinterface

// File: rtl/n64_sync_analyzer.sv
// n64_sync_analyzer
// Line counting, NTSC/PAL and 480i detection, and the deblur blanking register.
// Ports:
//   vclk, rst       : pixel clock, async active-high reset
//   sync_cycle      : current cycle is a sync cycle (nDSYNC low)
//   sync_in         : sync nibble on the bus this cycle
//   sync_prev       : previously latched sync nibble (for edge detection)
//   nvideblur       : low requests deblur blanking
//   palmode         : 1 = PAL, 0 = NTSC
//   n64_480i        : interlaced source detected
//   nblank          : 1 = next pixel may be committed
module n64_sync_analyzer
  import n64rgb_pkg::*;
#(
  parameter int LINE_W     = 10,
  parameter int PAL_THRESH = PAL_THRESH_DEF,
  parameter int MIN_LINES  = MIN_LINES_DEF
) (
  input  logic       vclk,
  input  logic       rst,
  input  logic       sync_cycle,
  input  logic [3:0] sync_in,
  input  logic [3:0] sync_prev,
  input  logic       nvideblur,
  output logic       palmode,
  output logic       n64_480i,
  output logic       nblank
);
  logic [LINE_W-1:0] line_cnt;
  logic              field_id;
  logic              hs_fall;
  logic              vs_fall;
  logic              cs_rise;
  logic              unused_clamp;

  assign hs_fall = sync_cycle && sync_prev[SYNC_HSYNC] && !sync_in[SYNC_HSYNC];
  assign vs_fall = sync_cycle && sync_prev[SYNC_VSYNC] && !sync_in[SYNC_VSYNC];
  assign cs_rise = sync_cycle && !sync_prev[SYNC_CSYNC] && sync_in[SYNC_CSYNC];
  assign unused_clamp = sync_in[SYNC_CLAMP] ^ sync_prev[SYNC_CLAMP];

  // A short (glitch) field still restarts the line count and updates the
  // field parity, but must not flip the PAL/NTSC decision.
  always_ff @(posedge vclk or posedge rst) begin
    if (rst) begin
      line_cnt <= '0;
      field_id <= 1'b0;
      palmode  <= 1'b0;
      n64_480i <= 1'b0;
    end else if (vs_fall) begin
      if (int'(line_cnt) >= MIN_LINES)
        palmode <= (int'(line_cnt) > PAL_THRESH);
      field_id <= hs_fall;
      n64_480i <= field_id ^ hs_fall;
      line_cnt <= '0;
    end else if (hs_fall && (line_cnt != '1)) begin
      line_cnt <= line_cnt + 1'b1;
    end
  end

  // Deblur: alternate pixels are held; the phase is re-aligned on each
  // composite sync rise so the blanked column is stable line to line.
  always_ff @(posedge vclk or posedge rst) begin
    if (rst) begin
      nblank <= 1'b1;
    end else if (sync_cycle) begin
      if (nvideblur || n64_480i)
        nblank <= 1'b1;
      else if (cs_rise)
        nblank <= palmode;
      else
        nblank <= ~nblank;
    end
  end

endmodule

// File: rtl/n64_vdemux_gen.sv
// n64_vdemux_gen
// Demultiplexes the N64 VI bus (sync, R, G, B per pixel) into registered
// parallel RGB with separate syncs, a pixel strobe and a malformed-pixel flag.
// Ports:
//   VCLK_i : VI pixel clock (rising edge)
//   RST_i  : asynchronous active-high reset
//   vi     : n64_vdemux_gen_if.slave (VI bus in, RGB/sync/status out)
// Optional feature macro: N64_TESTPAT_EN (8 vertical colour bars on TestPat_i).
module n64_vdemux_gen
  import n64rgb_pkg::*;
#(
  parameter int IN_W       = 7,
  parameter int OUT_W      = 8,
  parameter int LINE_W     = 10,
  parameter int PAL_THRESH = PAL_THRESH_DEF,
  parameter int MIN_LINES  = MIN_LINES_DEF
) (
  input logic             VCLK_i,
  input logic             RST_i,
  n64_vdemux_gen_if.slave vi
);
  phase_t           phase;
  phase_t           phase_nxt;
  logic [IN_W-1:0]  r_stg;
  logic [IN_W-1:0]  g_stg;
  logic [IN_W-1:0]  b_stg;
  logic [3:0]       sync_q;
  logic             seen_sync;
  logic             sync_cycle;
  logic             commit;
  logic             incomplete;
  logic             extra_data;
  logic             palmode;
  logic             n64_480i;
  logic             nblank;
  logic [OUT_W-1:0] r_q, g_q, b_q;
  logic [OUT_W-1:0] r_nxt, g_nxt, b_nxt;
  logic             pixel_valid_q;
  logic             phase_err_q;

  // Repeats the input value bit-wise from the MSB down: widening fills the
  // LSBs with the top bits, narrowing keeps the top OUT_W bits.
  function automatic logic [OUT_W-1:0] adapt(input logic [IN_W-1:0] v);
    logic [OUT_W-1:0] o;
    o = '0;
    for (int i = 0; i < OUT_W; i++)
      o[OUT_W-1-i] = v[IN_W-1-(i % IN_W)];
    return o;
  endfunction

  assign sync_cycle = ~vi.nDSYNC_i;
  assign commit     = sync_cycle && (phase == PH_DONE) && nblank;
  // The very first sync after reset has no preceding pixel to judge.
  assign incomplete = sync_cycle && (phase != PH_DONE) && seen_sync;
  assign extra_data = !sync_cycle && (phase == PH_DONE);

  always_ff @(posedge VCLK_i or posedge RST_i) begin
    if (RST_i) phase <= PH_R;
    else       phase <= phase_nxt;
  end

  always_comb begin
    phase_nxt = phase;
    if (sync_cycle) begin
      phase_nxt = PH_R;
    end else begin
      case (phase)
        PH_R:    phase_nxt = PH_G;
        PH_G:    phase_nxt = PH_B;
        PH_B:    phase_nxt = PH_DONE;
        default: phase_nxt = PH_DONE;
      endcase
    end
  end

  always_ff @(posedge VCLK_i or posedge RST_i) begin
    if (RST_i) begin
      r_stg <= '0;
      g_stg <= '0;
      b_stg <= '0;
    end else if (!sync_cycle) begin
      case (phase)
        PH_R:    r_stg <= vi.D_i;
        PH_G:    g_stg <= vi.D_i;
        PH_B:    b_stg <= vi.D_i;
        default: ;
      endcase
    end
  end

  always_ff @(posedge VCLK_i or posedge RST_i) begin
    if (RST_i) begin
      sync_q    <= 4'hF;
      seen_sync <= 1'b0;
    end else if (sync_cycle) begin
      sync_q    <= vi.D_i[3:0];
      seen_sync <= 1'b1;
    end
  end

  always_ff @(posedge VCLK_i or posedge RST_i) begin
    if (RST_i)                          phase_err_q <= 1'b0;
    else if (incomplete || extra_data)  phase_err_q <= 1'b1;
  end

`ifdef N64_TESTPAT_EN
  logic [9:0] pixel_cnt;
  logic       hsync_fall;
  logic [2:0] bar;

  assign hsync_fall = sync_cycle && sync_q[SYNC_HSYNC] && !vi.D_i[SYNC_HSYNC];
  assign bar        = test_bar(pixel_cnt[8:6]);

  always_ff @(posedge VCLK_i or posedge RST_i) begin
    if (RST_i)                              pixel_cnt <= '0;
    else if (hsync_fall)                    pixel_cnt <= '0;
    else if (commit && (pixel_cnt != '1))   pixel_cnt <= pixel_cnt + 1'b1;
  end

  always_comb begin
    r_nxt = adapt(r_stg);
    g_nxt = adapt(g_stg);
    b_nxt = adapt(b_stg);
    if (vi.TestPat_i) begin
      r_nxt = {OUT_W{bar[2]}};
      g_nxt = {OUT_W{bar[1]}};
      b_nxt = {OUT_W{bar[0]}};
    end
  end
`else
  logic unused_testpat;
  assign unused_testpat = vi.TestPat_i;

  always_comb begin
    r_nxt = adapt(r_stg);
    g_nxt = adapt(g_stg);
    b_nxt = adapt(b_stg);
  end
`endif

  always_ff @(posedge VCLK_i or posedge RST_i) begin
    if (RST_i) begin
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
      pixel_valid_q <= 1'b0;
    end else begin
      pixel_valid_q <= commit;
      if (commit) begin
        r_q <= r_nxt;
        g_q <= g_nxt;
        b_q <= b_nxt;
      end
    end
  end

  n64_sync_analyzer #(
    .LINE_W     (LINE_W),
    .PAL_THRESH (PAL_THRESH),
    .MIN_LINES  (MIN_LINES)
  ) u_sync_analyzer (
    .vclk       (VCLK_i),
    .rst        (RST_i),
    .sync_cycle (sync_cycle),
    .sync_in    (vi.D_i[3:0]),
    .sync_prev  (sync_q),
    .nvideblur  (vi.nViDeBlur_i),
    .palmode    (palmode),
    .n64_480i   (n64_480i),
    .nblank     (nblank)
  );

  assign vi.R_o           = r_q;
  assign vi.G_o           = g_q;
  assign vi.B_o           = b_q;
  assign vi.nVSYNC_o      = sync_q[SYNC_VSYNC];
  assign vi.nCLAMP_o      = sync_q[SYNC_CLAMP];
  assign vi.nHSYNC_o      = sync_q[SYNC_HSYNC];
  assign vi.nCSYNC_o      = sync_q[SYNC_CSYNC];
  assign vi.PIXEL_VALID_o = pixel_valid_q;
  assign vi.PALMODE_o     = palmode;
  assign vi.N64_480I_o    = n64_480i;
  assign vi.PHASE_ERR_o   = phase_err_q;

endmodule
